// File: rtl/frost_poly_share_eval_if.sv
// Handshake bundle between the FROST dealer front end and the share evaluator.
// The evaluator connects through the slave modport; the driving side uses master.
interface frost_poly_share_eval_if #(
  parameter int SCALAR_BITS = 253
) ();
  logic                   start;
  logic                   busy;
  logic                   coef_valid;
  logic                   coef_ready;
  logic [SCALAR_BITS-1:0] coef_data;
  logic                   share_valid;
  logic                   share_ready;
  logic [7:0]             share_idx;
  logic [SCALAR_BITS-1:0] share_data;
  logic                   done;
  logic [15:0]            eval_cycles;

  modport master (
    output start, coef_valid, coef_data, share_ready,
    input  busy, coef_ready, share_valid, share_idx, share_data, done, eval_cycles
  );

  modport slave (
    input  start, coef_valid, coef_data, share_ready,
    output busy, coef_ready, share_valid, share_idx, share_data, done, eval_cycles
  );
endinterface

// File: rtl/frost_poly_share_eval.sv
// Evaluates the dealer polynomial f(j) mod MODULUS for j = 1..NUM_NODES via Horner's rule
// using repeated modular addition. Optional run-length counter: FROST_EVAL_CYCLE_COUNT_EN.
module frost_poly_share_eval #(
  parameter int                     NUM_NODES   = 4,
  parameter int                     THRESHOLD   = 2,
  parameter int                     SCALAR_BITS = 253,
  parameter logic [SCALAR_BITS-1:0] MODULUS     =
    253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed
) (
  input  logic                   clk,
  input  logic                   rst_n,
  frost_poly_share_eval_if.slave bus
);

  localparam int            KW     = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
  localparam logic [KW-1:0] K_TOP  = KW'(THRESHOLD - 1);
  localparam logic [7:0]    J_LAST = 8'(NUM_NODES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_MUL, S_ADD, S_EMIT, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [SCALAR_BITS-1:0] coef_q [THRESHOLD];
  logic [SCALAR_BITS-1:0] acc_q, acc_d;
  logic [SCALAR_BITS-1:0] mul_acc_q, mul_acc_d;
  logic [7:0]             j_q, j_d;
  logic [7:0]             m_q, m_d;
  logic [KW-1:0]          k_q, k_d;
  logic [KW-1:0]          k_load_q, k_load_d;

  logic                   coef_fire;
  logic                   share_fire;
  logic [SCALAR_BITS-1:0] coef_red;
  logic [SCALAR_BITS-1:0] coef_sel;
  logic [SCALAR_BITS-1:0] acc_sum;
  logic [SCALAR_BITS-1:0] mul_sum;
  logic [7:0]             m_inc;

  function automatic logic [SCALAR_BITS-1:0] addm(input logic [SCALAR_BITS-1:0] x,
                                                  input logic [SCALAR_BITS-1:0] y);
    logic [SCALAR_BITS:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, MODULUS}) begin
      s = s - {1'b0, MODULUS};
    end
    return s[SCALAR_BITS-1:0];
  endfunction

  assign coef_fire  = bus.coef_valid && (state_q == S_LOAD);
  assign share_fire = bus.share_ready && (state_q == S_EMIT);
  // Input words may exceed the modulus by less than one modulus; one subtraction suffices.
  assign coef_red   = (bus.coef_data >= MODULUS) ? (bus.coef_data - MODULUS) : bus.coef_data;
  assign coef_sel   = coef_q[k_q];
  assign acc_sum    = addm(mul_acc_q, coef_sel);
  assign mul_sum    = addm(mul_acc_q, acc_q);
  assign m_inc      = m_q + 8'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: if (coef_fire && (k_load_q == '0)) state_d = S_INIT;
      // INIT always starts node 1, whose multiply step is a pass-through.
      S_INIT: state_d = S_ADD;
      S_MUL:  if (m_inc == j_q) state_d = S_ADD;
      S_ADD: begin
        if (k_q == '0) begin
          state_d = S_EMIT;
        end else if (j_q == 8'd1) begin
          state_d = S_ADD;
        end else begin
          state_d = S_MUL;
        end
      end
      S_EMIT: if (share_fire) state_d = (j_q == J_LAST) ? S_FIN : S_MUL;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.coef_ready  = (state_q == S_LOAD);
    bus.share_valid = (state_q == S_EMIT);
    bus.done        = (state_q == S_FIN);
  end

  assign bus.share_idx  = j_q;
  assign bus.share_data = acc_q;

  // Datapath next-state
  always_comb begin
    acc_d     = acc_q;
    mul_acc_d = mul_acc_q;
    j_d       = j_q;
    m_d       = m_q;
    k_d       = k_q;
    k_load_d  = k_load_q;
    unique case (state_q)
      S_IDLE: if (bus.start) k_load_d = K_TOP;
      S_LOAD: begin
        if (coef_fire && (k_load_q != '0)) k_load_d = k_load_q - KW'(1);
      end
      S_INIT: begin
        j_d       = 8'd1;
        acc_d     = '0;
        mul_acc_d = '0;
        m_d       = 8'd1;
        k_d       = K_TOP;
      end
      S_MUL: begin
        mul_acc_d = mul_sum;
        m_d       = m_inc;
      end
      S_ADD: begin
        acc_d = acc_sum;
        // Seed the next multiply with the freshly updated accumulator.
        if (k_q != '0) begin
          k_d       = k_q - KW'(1);
          mul_acc_d = acc_sum;
          m_d       = 8'd1;
        end
      end
      S_EMIT: begin
        if (share_fire && (j_q != J_LAST)) begin
          j_d       = j_q + 8'd1;
          acc_d     = '0;
          mul_acc_d = '0;
          m_d       = 8'd1;
          k_d       = K_TOP;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mul_acc_q <= '0;
      j_q       <= '0;
      m_q       <= '0;
      k_q       <= '0;
      k_load_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      mul_acc_q <= mul_acc_d;
      j_q       <= j_d;
      m_q       <= m_d;
      k_q       <= k_d;
      k_load_q  <= k_load_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < THRESHOLD; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_fire) begin
      coef_q[k_load_q] <= coef_red;
    end
  end

`ifdef FROST_EVAL_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] eval_q, eval_d;
  logic [15:0] cyc_inc;

  always_comb begin
    cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : (cyc_q + 16'd1);
    cyc_d   = cyc_q;
    eval_d  = eval_q;
    if (state_q == S_IDLE) begin
      if (bus.start) cyc_d = '0;
    end else begin
      cyc_d = cyc_inc;
    end
    // The FIN cycle itself is part of the run, hence the incremented value.
    if (state_q == S_FIN) eval_d = cyc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      eval_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      eval_q <= eval_d;
    end
  end

  assign bus.eval_cycles = eval_q;
`else
  assign bus.eval_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_frost_poly_share_eval.sv
// Directed bench for frost_poly_share_eval: a THRESHOLD=2 and a THRESHOLD=3 instance
// share clock and reset; each run drives one of them and checks every emitted share.
module tb_frost_poly_share_eval;
  localparam int             SB  = 253;
  localparam int             NN  = 4;
  localparam logic [SB-1:0]  MOD =
    253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  logic          clk;
  logic          rst_n;
  logic          start2, start3;
  logic          coef_valid;
  logic [SB-1:0] coef_data;
  logic          share_ready;
  logic          sel3;

  logic [SB-1:0] coef_tab [3];
  logic [SB-1:0] exp_tab  [NN];

  int n_checks;
  int n_fail;

  frost_poly_share_eval_if #(.SCALAR_BITS(SB)) bus2 ();
  frost_poly_share_eval_if #(.SCALAR_BITS(SB)) bus3 ();

  assign bus2.start       = start2;
  assign bus2.coef_valid  = coef_valid;
  assign bus2.coef_data   = coef_data;
  assign bus2.share_ready = share_ready;
  assign bus3.start       = start3;
  assign bus3.coef_valid  = coef_valid;
  assign bus3.coef_data   = coef_data;
  assign bus3.share_ready = share_ready;

  frost_poly_share_eval #(
    .NUM_NODES(NN), .THRESHOLD(2), .SCALAR_BITS(SB), .MODULUS(MOD)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  frost_poly_share_eval #(
    .NUM_NODES(NN), .THRESHOLD(3), .SCALAR_BITS(SB), .MODULUS(MOD)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  logic          o_busy, o_coef_ready, o_share_valid, o_done;
  logic [7:0]    o_share_idx;
  logic [SB-1:0] o_share_data;
  logic [15:0]   o_eval;

  assign o_busy        = sel3 ? bus3.busy        : bus2.busy;
  assign o_coef_ready  = sel3 ? bus3.coef_ready  : bus2.coef_ready;
  assign o_share_valid = sel3 ? bus3.share_valid : bus2.share_valid;
  assign o_done        = sel3 ? bus3.done        : bus2.done;
  assign o_share_idx   = sel3 ? bus3.share_idx   : bus2.share_idx;
  assign o_share_data  = sel3 ? bus3.share_data  : bus2.share_data;
  assign o_eval        = sel3 ? bus3.eval_cycles : bus2.eval_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full run: start, load coef_tab (highest degree first), collect NN shares.
  task automatic run_poly(input string name, input bit use3, input int nc, input int gap,
                          input int stall_idx, input bit busy_start, input int abort_after);
    int n, cyc, first_valid, wait_cyc, exp_cyc;
    bit stalled;
    n = 0; cyc = 0; first_valid = -1; stalled = 1'b0;
    sel3 = use3;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start3 = 1'b0;
    check_eq({name, "_busy_after_start"}, o_busy, 1);
    for (int i = 0; i < nc; i++) begin
      if (i > 0) begin
        coef_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      coef_valid = 1'b1;
      coef_data  = coef_tab[i];
      wait_cyc = 0;
      while (!o_coef_ready && wait_cyc < 50) begin
        @(negedge clk);
        wait_cyc++;
      end
      check_eq({name, "_coef_ready"}, o_coef_ready, 1);
      @(negedge clk);
    end
    coef_valid = 1'b0;
    coef_data  = '0;
    check_eq({name, "_coef_ready_low"}, o_coef_ready, 0);

    while (n < NN && cyc < 2000) begin
      start2 = 1'b0; start3 = 1'b0;
      if (busy_start && cyc == 4) begin
        if (use3) start3 = 1'b1; else start2 = 1'b1;
      end
      if (o_share_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (n + 1 == stall_idx && !stalled) begin
          stalled = 1'b1;
          share_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            cyc++;
            check_eq({name, "_stall_valid"}, o_share_valid, 1);
            check_eq({name, "_stall_idx"}, o_share_idx, n + 1);
            check_eq({name, "_stall_data"}, o_share_data, exp_tab[n]);
          end
          share_ready = 1'b1;
        end
        $display("%s share idx=%0d data=%0h", name, o_share_idx, o_share_data);
        check_eq({name, "_idx"}, o_share_idx, n + 1);
        check_eq({name, "_data"}, o_share_data, exp_tab[n]);
        check_eq({name, "_data_lt_mod"}, (o_share_data < MOD), 1);
        check_eq({name, "_done_early"}, o_done, 0);
        n++;
        if (n == abort_after) begin
          @(negedge clk);
          check_eq({name, "_busy_in_mul"}, o_busy, 1);
          rst_n = 1'b0;
          #1;
          check_eq({name, "_rst_busy"}, o_busy, 0);
          check_eq({name, "_rst_valid"}, o_share_valid, 0);
          check_eq({name, "_rst_done"}, o_done, 0);
          check_eq({name, "_rst_idx"}, o_share_idx, 0);
          check_eq({name, "_rst_data"}, o_share_data, 0);
          check_eq({name, "_rst_eval"}, o_eval, 0);
          @(negedge clk);
          rst_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            check_eq({name, "_post_rst_idle"}, {o_busy, o_share_valid, o_done}, 0);
          end
          return;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start2 = 1'b0; start3 = 1'b0;
    check_eq({name, "_share_count"}, n, NN);
    check_eq({name, "_first_latency"}, first_valid, nc + 1);
    check_eq({name, "_done_pulse"}, o_done, 1);
    check_eq({name, "_valid_after_last"}, o_share_valid, 0);
    @(negedge clk);
    check_eq({name, "_done_single"}, o_done, 0);
    check_eq({name, "_busy_end"}, o_busy, 0);
`ifdef FROST_EVAL_CYCLE_COUNT_EN
    // LOAD + INIT + nc*(1+2+..+NN) compute + EMIT (incl. stall) + FIN
    exp_cyc = nc + gap * (nc - 1) + 1 + nc * NN * (NN + 1) / 2 + NN
              + ((stall_idx > 0) ? 5 : 0) + 1;
`else
    exp_cyc = 0;
`endif
    check_eq({name, "_eval_cycles"}, o_eval, exp_cyc);
    repeat (2) @(negedge clk);
    check_eq({name, "_stays_idle"}, {o_busy, o_share_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start2 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
    coef_valid = 1'b0; coef_data = '0; share_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", o_busy, 0);
    check_eq("reset_coef_ready", o_coef_ready, 0);
    check_eq("reset_share_valid", o_share_valid, 0);
    check_eq("reset_done", o_done, 0);
    check_eq("reset_idx", o_share_idx, 0);
    check_eq("reset_data", o_share_data, 0);
    check_eq("reset_eval", o_eval, 0);
    rst_n = 1'b1;

    coef_tab[0] = 253'd3; coef_tab[1] = 253'd5;
    exp_tab[0] = 253'd8; exp_tab[1] = 253'd11; exp_tab[2] = 253'd14; exp_tab[3] = 253'd17;
    run_poly("basic", 1'b0, 2, 0, 0, 1'b0, 0);

    coef_tab[0] = 253'd1; coef_tab[1] = MOD - 253'd1;
    exp_tab[0] = 253'd0; exp_tab[1] = 253'd1; exp_tab[2] = 253'd2; exp_tab[3] = 253'd3;
    run_poly("wrap", 1'b0, 2, 0, 0, 1'b0, 0);

    coef_tab[0] = 253'd0; coef_tab[1] = MOD + 253'd7;
    for (int i = 0; i < NN; i++) exp_tab[i] = 253'd7;
    run_poly("reduce", 1'b0, 2, 0, 0, 1'b0, 0);

    coef_tab[0] = 253'd3; coef_tab[1] = 253'd5;
    exp_tab[0] = 253'd8; exp_tab[1] = 253'd11; exp_tab[2] = 253'd14; exp_tab[3] = 253'd17;
    run_poly("backpressure", 1'b0, 2, 3, 2, 1'b0, 0);
    run_poly("start_busy", 1'b0, 2, 0, 0, 1'b1, 0);
    run_poly("abort", 1'b0, 2, 0, 0, 1'b0, 2);
    run_poly("after_abort", 1'b0, 2, 0, 0, 1'b0, 0);

    coef_tab[0] = 253'd2; coef_tab[1] = 253'd0; coef_tab[2] = 253'd1;
    exp_tab[0] = 253'd3; exp_tab[1] = 253'd9; exp_tab[2] = 253'd19; exp_tab[3] = 253'd33;
    run_poly("t3", 1'b1, 3, 0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
